// File: rtl/plru_state_array.sv
// Tree pseudo-LRU state store with forwarding and a sequenced flush.
// Optional per-way invalid mask on queries: define PLRU_INV_MASK_EN.
module plru_state_array #(
   parameter int S_INDEX  = 4,
   parameter int NUM_WAYS = 4
) (
   input  logic                         clk0,
   input  logic                         rst0,
   output logic                         ready,
   input  logic                         q_valid,
   input  logic [S_INDEX-1:0]           q_addr,
   output logic                         q_resp_valid,
   output logic [$clog2(NUM_WAYS)-1:0]  q_victim,
   input  logic                         u_valid,
   input  logic [S_INDEX-1:0]           u_addr,
   input  logic [$clog2(NUM_WAYS)-1:0]  u_way,
`ifdef PLRU_INV_MASK_EN
   input  logic [NUM_WAYS-1:0]          q_inv_mask,
`endif
   input  logic                         flush
);

   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam int W_IDX    = $clog2(NUM_WAYS);
   localparam int TREE_W   = NUM_WAYS - 1;

   typedef enum logic {IDLE, FLUSH} state_e;

   state_e                state_q, state_d;
   logic [S_INDEX-1:0]    cnt_q, cnt_d;
   logic [TREE_W-1:0]     trees_q [NUM_SETS];
   logic [TREE_W-1:0]     trees_d [NUM_SETS];
   logic                  pend_v_q, pend_v_d;
   logic [S_INDEX-1:0]    pend_addr_q, pend_addr_d;
   logic [TREE_W-1:0]     pend_tree_q, pend_tree_d;
   logic                  qv_q, qv_d;
   logic [S_INDEX-1:0]    qa_q, qa_d;
   logic [W_IDX-1:0]      hold_q, hold_d;
`ifdef PLRU_INV_MASK_EN
   logic [NUM_WAYS-1:0]   mask_q, mask_d;
`endif

   logic                  q_acc, u_acc, f_acc;
   logic [TREE_W-1:0]     u_base, u_tree, r_tree;
   logic [W_IDX-1:0]      vict;

   function automatic logic [W_IDX-1:0] tree_victim(
      input logic [TREE_W-1:0] t
   );
      logic [W_IDX-1:0] idx;
      logic [W_IDX-1:0] v;
      logic             b;
      idx = '0;
      v   = '0;
      for (int l = 0; l < W_IDX; l++) begin
         b   = t[idx];
         v   = W_IDX'({v, b});
         idx = W_IDX'(2 * idx + 1 + b);
      end
      return v;
   endfunction

   // Each node on the path is flipped to point away from the touched way.
   function automatic logic [TREE_W-1:0] tree_touch(
      input logic [TREE_W-1:0] t,
      input logic [W_IDX-1:0]  w
   );
      logic [TREE_W-1:0] r;
      logic [W_IDX-1:0]  idx;
      logic [W_IDX-1:0]  ww;
      logic              b;
      r   = t;
      idx = '0;
      ww  = w;
      for (int l = 0; l < W_IDX; l++) begin
         b      = ww[W_IDX-1];
         ww     = ww << 1;
         r[idx] = ~b;
         idx    = W_IDX'(2 * idx + 1 + b);
      end
      return r;
   endfunction

   assign ready = (state_q == IDLE);
   assign q_acc = q_valid & ready;
   assign u_acc = u_valid & ready;
   assign f_acc = flush & ready;

   always_comb begin
      u_base = trees_q[u_addr];
      if (pend_v_q && pend_addr_q == u_addr)
         u_base = pend_tree_q;
      u_tree      = tree_touch(u_base, u_way);
      pend_v_d    = u_acc;
      pend_addr_d = u_acc ? u_addr : pend_addr_q;
      pend_tree_d = u_acc ? u_tree : pend_tree_q;
   end

   always_comb begin
      r_tree = trees_q[qa_q];
      if (pend_v_q && pend_addr_q == qa_q)
         r_tree = pend_tree_q;
      vict = tree_victim(r_tree);
`ifdef PLRU_INV_MASK_EN
      for (int i = NUM_WAYS - 1; i >= 0; i--)
         if (mask_q[i])
            vict = W_IDX'(i);
`endif
      q_resp_valid = qv_q;
      q_victim     = qv_q ? vict : hold_q;
      hold_d       = q_victim;
      qv_d         = q_acc;
      qa_d         = q_acc ? q_addr : qa_q;
`ifdef PLRU_INV_MASK_EN
      mask_d       = q_acc ? q_inv_mask : mask_q;
`endif
   end

   // Sweep write wins over a pending commit to the same set.
   always_comb begin
      trees_d = trees_q;
      if (pend_v_q)
         trees_d[pend_addr_q] = pend_tree_q;
      if (state_q == FLUSH)
         trees_d[cnt_q] = '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (f_acc) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == S_INDEX'(NUM_SETS - 1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         pend_tree_q <= '0;
         qv_q        <= 1'b0;
         qa_q        <= '0;
         hold_q      <= '0;
`ifdef PLRU_INV_MASK_EN
         mask_q      <= '0;
`endif
         for (int i = 0; i < NUM_SETS; i++)
            trees_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
         pend_tree_q <= pend_tree_d;
         qv_q        <= qv_d;
         qa_q        <= qa_d;
         hold_q      <= hold_d;
`ifdef PLRU_INV_MASK_EN
         mask_q      <= mask_d;
`endif
         trees_q     <= trees_d;
      end
   end

endmodule

// File: tb/tb_plru_state_array.sv
// Directed self-checking bench for plru_state_array (4 ways, 16 sets).
module tb_plru_state_array;

   logic       clk0 = 1'b0;
   logic       rst0;
   logic       ready;
   logic       q_valid;
   logic [3:0] q_addr;
   logic       q_resp_valid;
   logic [1:0] q_victim;
   logic       u_valid;
   logic [3:0] u_addr;
   logic [1:0] u_way;
   logic       flush;
`ifdef PLRU_INV_MASK_EN
   logic [3:0] q_inv_mask;
`endif

   int checks   = 0;
   int failures = 0;

   plru_state_array #(.S_INDEX(4), .NUM_WAYS(4)) dut (
      .clk0        (clk0),
      .rst0        (rst0),
      .ready       (ready),
      .q_valid     (q_valid),
      .q_addr      (q_addr),
      .q_resp_valid(q_resp_valid),
      .q_victim    (q_victim),
      .u_valid     (u_valid),
      .u_addr      (u_addr),
      .u_way       (u_way),
`ifdef PLRU_INV_MASK_EN
      .q_inv_mask  (q_inv_mask),
`endif
      .flush       (flush)
   );

   always #5 clk0 = ~clk0;

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic idle_inputs();
      q_valid = 1'b0;
      q_addr  = '0;
      u_valid = 1'b0;
      u_addr  = '0;
      u_way   = '0;
      flush   = 1'b0;
`ifdef PLRU_INV_MASK_EN
      q_inv_mask = '0;
`endif
   endtask

   task automatic query(input logic [3:0] a);
      q_valid = 1'b1;
      q_addr  = a;
      tick();
      q_valid = 1'b0;
   endtask

   task automatic touch(input logic [3:0] a, input logic [1:0] w);
      u_valid = 1'b1;
      u_addr  = a;
      u_way   = w;
      tick();
      u_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst0 = 1'b1;
      idle_inputs();
      #12;
      checks++;
      if (ready !== 1'b1 || q_resp_valid !== 1'b0 || q_victim !== 2'd0) begin
         failures++;
         $display("FAIL reset: ready=%b rv=%b vict=%0d want 1 0 0",
                  ready, q_resp_valid, q_victim);
      end
      @(negedge clk0);
      rst0 = 1'b0;
      tick();
   endtask

   task automatic test_query_all();
      for (int s = 0; s < 16; s++) begin
         query(4'(s));
         checks++;
         if (q_resp_valid !== 1'b1 || q_victim !== 2'd0) begin
            failures++;
            $display("FAIL query_all set %0d: rv=%b vict=%0d want 1 0",
                     s, q_resp_valid, q_victim);
         end
         tick();
         checks++;
         if (q_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL query_pulse set %0d: rv=%b want 0",
                     s, q_resp_valid);
         end
      end
   endtask

   task automatic test_update_all_ways();
      for (int w = 0; w < 4; w++)
         touch(4'd3, 2'(w));
      query(4'd3);
      checks++;
      if (q_resp_valid !== 1'b1 || q_victim !== 2'd0) begin
         failures++;
         $display("FAIL all_ways: rv=%b vict=%0d want 1 0",
                  q_resp_valid, q_victim);
      end
      tick();
      touch(4'd3, 2'd0);
      touch(4'd3, 2'd2);
      query(4'd3);
      checks++;
      if (q_victim !== 2'd1) begin
         failures++;
         $display("FAIL ways_0_2: vict=%0d want 1", q_victim);
      end
      tick();
      checks++;
      if (q_resp_valid !== 1'b0 || q_victim !== 2'd1) begin
         failures++;
         $display("FAIL hold: rv=%b vict=%0d want 0 1",
                  q_resp_valid, q_victim);
      end
   endtask

   task automatic test_same_cycle();
      u_valid = 1'b1;
      u_addr  = 4'd5;
      u_way   = 2'd0;
      query(4'd5);
      u_valid = 1'b0;
      checks++;
      if (q_resp_valid !== 1'b1 || q_victim !== 2'd2) begin
         failures++;
         $display("FAIL same_cycle: rv=%b vict=%0d want 1 2",
                  q_resp_valid, q_victim);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      touch(4'd7, 2'd0);
      touch(4'd7, 2'd2);
      query(4'd7);
      checks++;
      if (q_victim !== 2'd1) begin
         failures++;
         $display("FAIL back_to_back: vict=%0d want 1", q_victim);
      end
      tick();
      query(4'd7);
      checks++;
      if (q_victim !== 2'd1) begin
         failures++;
         $display("FAIL b2b_committed: vict=%0d want 1", q_victim);
      end
      tick();
   endtask

   task automatic test_flush();
      int  lows;
      bit  leak;
      logic [1:0] post [4];
      logic [3:0] sets [4];
      sets[0] = 4'd0;
      sets[1] = 4'd1;
      sets[2] = 4'd2;
      sets[3] = 4'd15;
      touch(4'd1, 2'd0);
      touch(4'd2, 2'd0);
      touch(4'd15, 2'd3);
      // flush together with a query (pre-flush view) and an update
      flush   = 1'b1;
      u_valid = 1'b1;
      u_addr  = 4'd0;
      u_way   = 2'd0;
      query(4'd1);
      flush   = 1'b0;
      u_valid = 1'b0;
      checks++;
      if (q_resp_valid !== 1'b1 || q_victim !== 2'd2) begin
         failures++;
         $display("FAIL flush_preview: rv=%b vict=%0d want 1 2",
                  q_resp_valid, q_victim);
      end
      lows = 0;
      leak = 1'b0;
      q_valid = 1'b1;
      q_addr  = 4'd2;
      while (ready === 1'b0 && lows < 40) begin
         lows++;
         tick();
         if (ready === 1'b1)
            q_valid = 1'b0;
         if (q_resp_valid !== 1'b0)
            leak = 1'b1;
      end
      q_valid = 1'b0;
      checks++;
      if (lows !== 16) begin
         failures++;
         $display("FAIL flush_len: low=%0d want 16", lows);
      end
      checks++;
      if (leak !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop: resp seen=%b want 0", leak);
      end
      for (int i = 0; i < 4; i++) begin
         query(sets[i]);
         post[i] = q_victim;
         checks++;
         if (q_resp_valid !== 1'b1 || post[i] !== 2'd0) begin
            failures++;
            $display("FAIL post_flush set %0d: rv=%b vict=%0d want 1 0",
                     sets[i], q_resp_valid, post[i]);
         end
      end
      tick();
   endtask

   task automatic test_flush_ignored();
      int lows;
      flush = 1'b1;
      tick();
      lows = 0;
      while (ready === 1'b0 && lows < 40) begin
         lows++;
         tick();
      end
      flush = 1'b0;
      checks++;
      if (lows !== 16) begin
         failures++;
         $display("FAIL flush_held: low=%0d want 16", lows);
      end
      tick();
   endtask

`ifdef PLRU_INV_MASK_EN
   task automatic test_inv_mask();
      touch(4'd9, 2'd0);
      q_inv_mask = 4'b1010;
      query(4'd9);
      q_inv_mask = '0;
      checks++;
      if (q_victim !== 2'd1) begin
         failures++;
         $display("FAIL inv_mask: vict=%0d want 1", q_victim);
      end
      query(4'd9);
      checks++;
      if (q_victim !== 2'd2) begin
         failures++;
         $display("FAIL inv_mask_zero: vict=%0d want 2", q_victim);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_query_all();
      test_update_all_ways();
      test_same_cycle();
      test_back_to_back();
      test_flush();
      test_flush_ignored();
`ifdef PLRU_INV_MASK_EN
      test_inv_mask();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
